// File: rtl/mul32_seq_pkg.sv
// Shared constants for the sequential shift-add multiplier: operand width,
// iteration counter width, FSM encodings and the operand magnitude helper.
package mul32_seq_pkg;

    localparam int N  = 32;
    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Signed 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] value, input logic is_signed);
        logic [N-1:0] result;
        if (is_signed && value[N-1]) begin
            result = ~value + {{(N-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/mul32_seq_neg64.sv
// Combinational 2N-bit conditional two's-complement negate used to apply the
// product sign after the unsigned magnitude multiply.
module mul32_seq_neg64
    import mul32_seq_pkg::*;
(
    input  logic [2*N-1:0] value,
    input  logic           neg,
    output logic [2*N-1:0] product
);

    // Negate modulo 2^(2N) when the operand signs differed.
    always_comb begin
        product = value;
        if (neg) begin
            product = ~value + {{(2*N-1){1'b0}}, 1'b1};
        end else begin
            product = value;
        end
    end

endmodule

// File: rtl/mul32_seq.sv
// Sequential 32x32 shift-add multiplier: one multiplier bit per CALC cycle,
// a FIX cycle for the sign, and a registered 64-bit product on Hi/Lo.
module mul32_seq
    import mul32_seq_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic         Sign,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Hi,
    output logic [N-1:0] Lo
);

    logic [1:0]     state_r;
    logic [1:0]     next_state_s;
    logic           neg_r;
    logic [2*N-1:0] mcand_r;
    logic [N-1:0]   mplier_r;
    logic [2*N-1:0] acc_r;
    logic [CW-1:0]  count_r;
    logic [N-1:0]   hi_r;
    logic [N-1:0]   lo_r;
    logic           accept_s;
    logic [2*N-1:0] product_s;

    assign accept_s = Start && ((state_r == S_IDLE) || (state_r == S_DONE));

    // Next-state decode for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (Start) next_state_s = S_CALC;
                else       next_state_s = S_IDLE;
            end
            S_CALC: begin
                if (count_r == CW'(N-1)) next_state_s = S_FIX;
                else                     next_state_s = S_CALC;
            end
            S_FIX:  next_state_s = S_DONE;
            S_DONE: begin
                if (Start) next_state_s = S_CALC;
                else       next_state_s = S_IDLE;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    mul32_seq_neg64 u_neg64 (
        .value   (acc_r),
        .neg     (neg_r),
        .product (product_s)
    );

    // State, operand latch, shift-add iteration and result registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r  <= S_IDLE;
            neg_r    <= 1'b0;
            mcand_r  <= {(2*N){1'b0}};
            mplier_r <= {N{1'b0}};
            acc_r    <= {(2*N){1'b0}};
            count_r  <= {CW{1'b0}};
            hi_r     <= {N{1'b0}};
            lo_r     <= {N{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                neg_r    <= Sign & (A[N-1] ^ B[N-1]);
                mcand_r  <= {{N{1'b0}}, magnitude(A, Sign)};
                mplier_r <= magnitude(B, Sign);
                acc_r    <= {(2*N){1'b0}};
                count_r  <= {CW{1'b0}};
            end else if (state_r == S_CALC) begin
                // mcand_r is pre-shifted each cycle, so it always equals |A| << count.
                if (mplier_r[0]) begin
                    acc_r <= acc_r + mcand_r;
                end
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                count_r  <= count_r + CW'(1);
            end
            if (state_r == S_FIX) begin
                hi_r <= product_s[2*N-1:N];
                lo_r <= product_s[N-1:0];
            end
        end
    end

    assign Busy = (state_r == S_CALC) || (state_r == S_FIX);
    assign Done = (state_r == S_DONE);
    assign Hi   = hi_r;
    assign Lo   = lo_r;

endmodule
